uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 109000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rxd  in  1  asynchronous serial input; idle high.
REQ-007 rd_en  in  1  pop the head byte.
REQ-008 rd_data  out  8  head byte (show-ahead); valid while empty=0.
REQ-009 empty  out  1  FIFO holds no bytes.
REQ-010 full  out  1  FIFO holds DEPTH bytes.
REQ-011 overrun  out  1  sticky: a received byte was dropped because the FIFO was full.
REQ-012 frame_err  out  1  sticky: a stop bit was sampled low.
REQ-013 parity_err  out  1  sticky: parity mismatch; tied 0 unless the macro in REQ-031 is defined.
REQ-014 clr_err  in  1  clears all sticky flags.

Function
REQ-015 SHALL pass rxd through a 2-FF synchronizer before any use.
REQ-016 SHALL generate a 16x oversample tick every CLK_FREQ/(BAUD*16) clocks, using integer truncation.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH, plus PARITY when the macro in REQ-031 is defined.
REQ-018 IDLE -> START on synchronized rxd=0; the tick counter restarts at that edge.
REQ-019 START: sample at 8 ticks; 1 -> IDLE (glitch, no flag); 0 -> DATA.
REQ-020 DATA: sample every 16 ticks, 8 bits, LSB first; then go to STOP (or PARITY).
REQ-021 STOP: sample at 16 ticks; 1 -> push the byte, go to IDLE; 0 -> set frame_err, discard the byte, go to WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE on synchronized rxd=1.
REQ-023 Push latency: empty=0 and rd_data valid on the clock after the stop-bit sample.
REQ-024 Push while full with no rd_en: drop the byte, set overrun, leave FIFO contents unchanged.
REQ-025 Push and rd_en in the same cycle while full: both take effect; count unchanged; overrun not set.
REQ-026 rd_en while empty SHALL be ignored; pointers unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy count of width log2(DEPTH)+1.
REQ-028 clr_err and a flag-set event in the same cycle: set wins.

Reset
REQ-029 rst SHALL force FSM=IDLE, both pointers and count=0, empty=1, full=0, overrun=frame_err=parity_err=0, rd_data=0, synchronizer FFs=1, and tick divider=0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no push and no flag; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: a PARITY state follows DATA, sampled 16 ticks later and checked for even parity; on mismatch, set parity_err, discard the byte, then proceed to STOP. Undefined: 8N1 framing only, no PARITY state, parity_err tied 0.

Structure
REQ-032 Shared package uart_pkg SHALL hold the rx FSM state enum, constant OVS=16, and the default DEPTH.
REQ-033 The tick divider SHALL be sub-module uart_baud_tick, with ports clk, rst, restart, and tick.

Verification (CLK_FREQ=1600000, BAUD=10000: 10 clk/tick, 160 clk/bit)
REQ-034 Serial 0x55 8N1 -> empty falls 1 clk after the stop sample (~1520 clk after the start edge); rd_data=0x55; no flags.
REQ-035 40-clk low pulse on idle line -> no push; empty=1; no flags.
REQ-036 0xA3 with stop bit 0 -> frame_err=1, empty=1; next byte 0x12 sent normally -> received as 0x12.
REQ-037 Bytes 0x00..0x10 sent without reads (DEPTH=16) -> full=1, overrun=1; 16 pops return 0x00..0x0F in order, then empty=1.
REQ-038 rst pulsed during DATA of 0xFF, then 0x3C sent -> only 0x3C read; no flags.
REQ-039 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err=1, byte discarded; 0x07 with parity bit 1 -> received as 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: rx FSM state encoding, oversample ratio, default FIFO depth.
package uart_pkg;

    localparam int unsigned OVS           = 16;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t StIdle     = 3'd0;
    localparam rx_state_t StStart    = 3'd1;
    localparam rx_state_t StData     = 3'd2;
    localparam rx_state_t StStop     = 3'd3;
    localparam rx_state_t StWaitHigh = 3'd4;
    localparam rx_state_t StParity   = 3'd5;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator; restart realigns the divider to a start-bit edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 109000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead byte FIFO
// with sticky overrun / framing / parity error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 109000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    input  logic       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] HALF_TICK = 4'(OVS / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);

    logic rxd_meta, rxd_s;
    logic tick, restart, push, frame_set, par_bad;
    rx_state_t state, state_d;
    logic [3:0] ovs, ovs_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic [7:0] shreg, shreg_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = StParity;
    logic par_sample, par_mismatch;

    assign par_sample   = (state == StParity) && tick && (ovs == LAST_TICK);
    assign par_mismatch = ^{shreg, rxd_s};

    // par_bad blocks the push of the current frame; parity_err is the sticky report.
    always_ff @(posedge clk) begin
        if (rst || state == StStart) begin
            par_bad <= 1'b0;
        end else if (par_sample && par_mismatch) begin
            par_bad <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (par_sample && par_mismatch) begin
            parity_err <= 1'b1;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`else
    localparam rx_state_t AFTER_DATA = StStop;
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        ovs_d     = ovs;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        restart   = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            StIdle: begin
                if (!rxd_s) begin
                    restart = 1'b1;
                    ovs_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    ovs_d = ovs + 1'b1;
                    if (ovs == HALF_TICK) begin
                        ovs_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rxd_s ? StIdle : StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    ovs_d = ovs + 1'b1;
                    if (ovs == LAST_TICK) begin
                        ovs_d     = '0;
                        shreg_d   = {rxd_s, shreg[7:1]};
                        bit_idx_d = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    ovs_d = ovs + 1'b1;
                    if (ovs == LAST_TICK) begin
                        ovs_d   = '0;
                        state_d = StStop;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    ovs_d = ovs + 1'b1;
                    if (ovs == LAST_TICK) begin
                        ovs_d = '0;
                        if (rxd_s) begin
                            push    = !par_bad;
                            state_d = StIdle;
                        end else begin
                            frame_set = 1'b1;
                            state_d   = StWaitHigh;
                        end
                    end
                end
            end
            StWaitHigh: begin
                if (rxd_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            ovs     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_d;
            ovs     <= ovs_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
        end
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_ok, rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_ok = push && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push && full && !rd_en) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (frame_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 1.6 MHz / 10 kbaud; UART_RX_PARITY_EN adds the parity case.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 10000;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overrun, frame_err, parity_err;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         rd_auto = 1'b0;
`ifdef UART_RX_PARITY_EN
    bit         par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .clr_err    (clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops whenever a byte is presented and compares it with the scoreboard head.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (rd_auto && !rst && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", rd_data);
                end else begin
                    check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rxd = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_flags(input string name, input logic ov, input logic fe, input logic pe);
        check({name, "_overrun"}, {31'h0, overrun}, {31'h0, ov});
        check({name, "_frame_err"}, {31'h0, frame_err}, {31'h0, fe});
        check({name, "_parity_err"}, {31'h0, parity_err}, {31'h0, pe});
    endtask

    initial begin
        int lat;
        int waited;

        repeat (4) @(negedge clk);
        check("reset_empty", {31'h0, empty}, 32'h1);
        check("reset_full", {31'h0, full}, 32'h0);
        check("reset_rd_data", {24'h0, rd_data}, 32'h0);
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        rd_auto = 1'b1;
        repeat (5) @(negedge clk);

        // 0x55: push visible 3 sync/restart clocks + 152 ticks * 10 clk after the start edge.
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (empty && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency_0x55", lat, 1523);
        check_flags("byte_0x55", 1'b0, 1'b0, 1'b0);

        // Short low glitch must be rejected at the mid-start sample.
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_empty", {31'h0, empty}, 32'h1);
        check_flags("glitch", 1'b0, 1'b0, 1'b0);

        send_frame(8'hA3, 1'b0);
        check("framing_empty", {31'h0, empty}, 32'h1);
        check("framing_frame_err", {31'h0, frame_err}, 32'h1);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        check("frame_err_sticky", {31'h0, frame_err}, 32'h1);
        pulse_clr();
        check("frame_err_cleared", {31'h0, frame_err}, 32'h0);

        // Fill past DEPTH with the reader stalled: 17th byte is dropped.
        rd_auto = 1'b0;
        for (int b = 0; b <= 16; b++) begin
            if (b < 16) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        check("fill_full", {31'h0, full}, 32'h1);
        check("fill_empty", {31'h0, empty}, 32'h0);
        check("fill_overrun", {31'h0, overrun}, 32'h1);
        rd_auto = 1'b1;
        waited = 0;
        while ((!empty || exp_q.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", {31'h0, empty}, 32'h1);
        check("drain_full", {31'h0, full}, 32'h0);
        check("drain_queue", exp_q.size(), 0);
        pulse_clr();
        check("overrun_cleared", {31'h0, overrun}, 32'h0);

        // Reset in the middle of a 0xFF data phase aborts it silently.
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6 * BIT_CLKS - 3 + 20) @(negedge clk);
        check("abort_empty", {31'h0, empty}, 32'h1);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check_flags("after_abort", 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        check("parity_bad_empty", {31'h0, empty}, 32'h1);
        check("parity_bad_flag", {31'h0, parity_err}, 32'h1);
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        check("parity_sticky", {31'h0, parity_err}, 32'h1);
        pulse_clr();
        check("parity_cleared", {31'h0, parity_err}, 32'h0);
`endif

        repeat (20) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        check("final_empty", {31'h0, empty}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
